seq_detector_param: RTL and testbench

//  Parametrised serial bit-pattern detector. Generalises the fixed 4-bit "1100" Mealy detector.

---
 rtl/seq_det_pkg.sv | 20 ++
 rtl/seq_match_counter.sv | 34 +++
 rtl/seq_detector_param.sv | 132 +++++++++++++
 tb/tb_seq_detector_param.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seq_det_pkg
// Brief    : Shared constants and helpers for the serial pattern detector.
// Revision : 1.0 - initial release
// ============================================================================
package seq_det_pkg;

    localparam logic       FOUND       = 1'b1;
    localparam logic       NOTFOUND    = 1'b0;
    localparam logic [3:0] DEF_PATTERN = 4'b1100;
    localparam int         DEF_LEN     = 4;

    // Width needed to hold a pattern length of 0..max_len (LEN_W).
    function automatic int len_width(input int max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_match_counter.sv
`default_nettype none
// ============================================================================
// Module   : seq_match_counter
// Brief    : Saturating match counter; clear takes priority over increment.
// Revision : 1.0 - initial release
// ============================================================================
module seq_match_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic             sat
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc && !(&r_count)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign count = r_count;
    assign sat   = &r_count;

endmodule
`default_nettype wire

// File: rtl/seq_detector_param.sv
`default_nettype none
// ============================================================================
// Module   : seq_detector_param
// Brief    : Run-time programmable serial bit-pattern detector with counter.
// Revision : 1.0 - initial release
// ============================================================================
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN        = 8,
    parameter int CNT_W          = 8,
    parameter int REGISTERED_OUT = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         x,
    input  logic                         x_valid,
    input  logic                         cfg_we,
    input  logic [MAX_LEN-1:0]           cfg_pattern,
    input  logic [$clog2(MAX_LEN+1)-1:0] cfg_len,
    input  logic                         cfg_overlap,
    input  logic                         cnt_clr,
    output logic                         y,
    output logic [CNT_W-1:0]             match_count,
    output logic                         count_sat
);

    localparam int                 LEN_W         = len_width(MAX_LEN);
    localparam logic [LEN_W-1:0]   FILL_0        = '0;
    localparam logic [LEN_W-1:0]   FILL_MAX      = LEN_W'(MAX_LEN);
    localparam logic [MAX_LEN-1:0] C_DEF_PATTERN = MAX_LEN'(DEF_PATTERN);
    localparam logic [LEN_W-1:0]   C_DEF_LEN     = LEN_W'(DEF_LEN);

    logic [MAX_LEN-1:0] r_pattern;
    logic [LEN_W-1:0]   r_len;
    logic               r_overlap;
    logic [MAX_LEN-1:0] r_hist;
    logic [LEN_W-1:0]   r_fill;
    logic [LEN_W-1:0]   w_fill_next;
    logic               w_consume;
    logic               w_hit;
    logic [MAX_LEN-1:0] w_window;
    logic [MAX_LEN-1:0] w_mask;
    logic               w_fill_ok;

    // A simultaneous config write wins over the data bit.
    assign w_consume = x_valid & ~cfg_we;
    assign w_window  = {r_hist[MAX_LEN-2:0], x};

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pattern <= C_DEF_PATTERN;
            r_len     <= C_DEF_LEN;
            r_overlap <= 1'b1;
        end else if (cfg_we) begin
            r_pattern <= cfg_pattern;
            r_len     <= (cfg_len > FILL_MAX) ? FILL_MAX : cfg_len;
            r_overlap <= cfg_overlap;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_hist <= '0;
        end else if (w_consume) begin
            r_hist <= {r_hist[MAX_LEN-2:0], x};
        end
    end

    // Fill-level FSM: state register
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_fill <= FILL_0;
        end else begin
            r_fill <= w_fill_next;
        end
    end

    // Fill-level FSM: next state
    always_comb begin
        w_fill_next = r_fill;
        if (cfg_we) begin
            w_fill_next = FILL_0;
        end else if (w_consume) begin
            if (w_hit && !r_overlap) begin
                w_fill_next = FILL_0;
            end else if (r_fill != FILL_MAX) begin
                w_fill_next = r_fill + LEN_W'(1);
            end
        end
    end

    // Fill-level FSM: output (comparator); only the newest len bits take part
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            w_mask[i] = (i < int'(r_len));
        end
        w_fill_ok = (int'(r_fill) + 1) >= int'(r_len);
        w_hit     = w_consume && (r_len != FILL_0) && w_fill_ok &&
                    (((w_window ^ r_pattern) & w_mask) == '0);
    end

    generate
        if (REGISTERED_OUT != 0) begin : g_reg_out
            logic r_y_q;
            always_ff @(posedge clk) begin
                if (!reset) begin
                    r_y_q <= NOTFOUND;
                end else begin
                    r_y_q <= w_hit;
                end
            end
            assign y = reset ? r_y_q : NOTFOUND;
        end else begin : g_mealy_out
            assign y = (reset && w_hit) ? FOUND : NOTFOUND;
        end
    endgenerate

    seq_match_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clk   (clk),
        .reset (reset),
        .inc   (w_hit),
        .clr   (cnt_clr),
        .count (match_count),
        .sat   (count_sat)
    );

endmodule
`default_nettype wire

// File: tb/tb_seq_detector_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_detector_param
// Brief    : Directed bench for seq_detector_param (Mealy and registered outputs).
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_detector_param;

    logic       clk = 1'b0;
    logic       reset, x, x_valid, cfg_we, cfg_overlap, cnt_clr;
    logic [7:0] cfg_pattern;
    logic [3:0] cfg_len;
    logic       y_m, y_r, sat_m, sat_r;
    logic [1:0] cnt_m;
    logic [7:0] cnt_r;
    bit         q_m[$];
    bit         q_r[$];
    int         checks   = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    seq_detector_param #(.MAX_LEN(8), .CNT_W(2), .REGISTERED_OUT(0)) dut_m (
        .clk(clk), .reset(reset), .x(x), .x_valid(x_valid), .cfg_we(cfg_we),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
        .cnt_clr(cnt_clr), .y(y_m), .match_count(cnt_m), .count_sat(sat_m)
    );

    seq_detector_param #(.MAX_LEN(8), .CNT_W(8), .REGISTERED_OUT(1)) dut_r (
        .clk(clk), .reset(reset), .x(x), .x_valid(x_valid), .cfg_we(cfg_we),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
        .cnt_clr(cnt_clr), .y(y_r), .match_count(cnt_r), .count_sat(sat_r)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One clock of stimulus; Mealy y is checked just before the edge,
    // registered y just after it.
    task automatic step(input logic xv, input logic xb, input bit exp_y, input string tag);
        bit e;
        @(negedge clk);
        x_valid = xv;
        x       = xb;
        q_m.push_back(exp_y);
        q_r.push_back(exp_y);
        #4;
        e = q_m.pop_front();
        chk({tag, " y"}, {31'd0, y_m}, {31'd0, e});
        @(posedge clk);
        #1;
        e = q_r.pop_front();
        chk({tag, " y_reg"}, {31'd0, y_r}, {31'd0, e});
        cfg_we  = 1'b0;
        cnt_clr = 1'b0;
        x_valid = 1'b0;
    endtask

    // Sends b[n-1] first; h gives the expected y for each bit in the same order.
    task automatic bits(input logic [7:0] b, input int n, input logic [7:0] h, input string tag);
        for (int i = n - 1; i >= 0; i--) begin
            step(1'b1, b[i], h[i], tag);
        end
    endtask

    task automatic cfg(input logic [7:0] p, input logic [3:0] l, input logic ov);
        cfg_pattern = p;
        cfg_len     = l;
        cfg_overlap = ov;
        cfg_we      = 1'b1;
        step(1'b0, 1'b0, 1'b0, "cfg");
    endtask

    task automatic clear_count();
        cnt_clr = 1'b1;
        step(1'b0, 1'b0, 1'b0, "clr");
    endtask

    initial begin
        reset = 1'b0; x = 1'b0; x_valid = 1'b0; cfg_we = 1'b0;
        cfg_pattern = 8'h00; cfg_len = 4'd0; cfg_overlap = 1'b0; cnt_clr = 1'b0;

        step(1'b1, 1'b1, 1'b0, "rst");
        step(1'b1, 1'b1, 1'b0, "rst");
        chk("rst cnt", {30'd0, cnt_m}, 32'd0);
        chk("rst sat", {31'd0, sat_m}, 32'd0);
        chk("rst cnt_reg", {24'd0, cnt_r}, 32'd0);
        reset = 1'b1;

        // Default 1100
        bits(8'b1100, 4, 8'b0001, "t1");
        chk("t1 cnt", {30'd0, cnt_m}, 32'd1);
        chk("t1 cnt_reg", {24'd0, cnt_r}, 32'd1);
        clear_count();

        // 101 with and without overlap
        cfg(8'b101, 4'd3, 1'b1);
        bits(8'b10101, 5, 8'b00101, "t2ov");
        chk("t2ov cnt", {30'd0, cnt_m}, 32'd2);
        clear_count();
        cfg(8'b101, 4'd3, 1'b0);
        bits(8'b10101, 5, 8'b00100, "t2nov");
        chk("t2nov cnt", {30'd0, cnt_m}, 32'd1);
        clear_count();

        // Gaps in x_valid do not break the match
        cfg(8'b1100, 4'd4, 1'b1);
        bits(8'b11, 2, 8'b00, "t3a");
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, "t3gap");
        bits(8'b00, 2, 8'b01, "t3b");
        chk("t3 cnt", {30'd0, cnt_m}, 32'd1);
        clear_count();

        // Config write with valid data: bit discarded
        bits(8'b110, 3, 8'b000, "t4a");
        cfg_pattern = 8'b0011; cfg_len = 4'd4; cfg_overlap = 1'b1; cfg_we = 1'b1;
        step(1'b1, 1'b0, 1'b0, "t4cfg");
        bits(8'b0011, 4, 8'b0001, "t4b");
        chk("t4 cnt", {30'd0, cnt_m}, 32'd1);
        clear_count();

        // Saturation and clear-vs-hit priority
        cfg(8'b1, 4'd1, 1'b1);
        bits(8'b11111, 5, 8'b11111, "t5");
        chk("t5 cnt", {30'd0, cnt_m}, 32'd3);
        chk("t5 sat", {31'd0, sat_m}, 32'd1);
        chk("t5 cnt_reg", {24'd0, cnt_r}, 32'd5);
        chk("t5 sat_reg", {31'd0, sat_r}, 32'd0);
        cnt_clr = 1'b1;
        step(1'b1, 1'b1, 1'b1, "t5clr");
        chk("t5clr cnt", {30'd0, cnt_m}, 32'd0);
        chk("t5clr sat", {31'd0, sat_m}, 32'd0);
        chk("t5clr cnt_reg", {24'd0, cnt_r}, 32'd0);

        // Length 0 disables; oversize length clamps to 8
        cfg(8'h00, 4'd0, 1'b1);
        bits(8'b00, 2, 8'b00, "len0");
        cfg(8'hA5, 4'd15, 1'b1);
        bits(8'hA5, 8, 8'b00000001, "lenclamp");
        chk("lenclamp cnt", {30'd0, cnt_m}, 32'd1);

        // Mid-stream reset restores default pattern and discards history
        bits(8'b110, 3, 8'b000, "t6a");
        reset = 1'b0;
        step(1'b0, 1'b0, 1'b0, "t6rst");
        reset = 1'b1;
        step(1'b1, 1'b0, 1'b0, "t6b");
        bits(8'b1100, 4, 8'b0001, "t6c");
        chk("t6 cnt", {30'd0, cnt_m}, 32'd1);
        chk("t6 cnt_reg", {24'd0, cnt_r}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
